// File: rtl/mips32_multicycle_if.sv
// Instruction-fetch bus between the multicycle core (master) and its instruction memory (slave).
// The word at instr_addr is accepted in any cycle where instr_req and instr_valid are both high.
interface mips32_multicycle_if #(
    parameter int IMEM_AW = 6
);
    logic               instr_req;
    logic [IMEM_AW-1:0] instr_addr;
    logic               instr_valid;
    logic [31:0]        instr;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_valid,
        input  instr
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_valid,
        output instr
    );
endinterface

// File: rtl/mips32_multicycle.sv
// Multi-cycle MIPS32 subset core: FETCH/DECODE/EXECUTE/MEM/WB FSM, internal data RAM,
// and a terminal HALT state entered on BREAK.
module mips32_multicycle #(
    parameter int IMEM_AW    = 6,
    parameter int DMEM_AW    = 7,
    parameter int NREGS_LOG2 = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    mips32_multicycle_if.master  bus,
    output logic                 halted,
    output logic [31:0]          halt_value,
    output logic [31:0]          retired
);
    localparam int NREGS = 1 << NREGS_LOG2;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {K_RALU, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_BREAK, K_BAD} kind_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic [31:0]     ir_reg;
    logic [31:0]     a_reg;
    logic [31:0]     b_reg;
    logic [31:0]     alu_out_reg;
    logic [31:0]     mem_rdata_reg;
    logic            instr_req_reg;
    logic            halted_reg;
    logic [31:0]     halt_value_reg;
    logic [31:0]     retired_reg;
    logic [31:0]     regs_reg [NREGS];
    logic [31:0]     dmem [2**DMEM_AW];

    kind_t                 kind;
    logic [31:0]           imm;
    logic [31:0]           pc4;
    logic [31:0]           br_target;
    logic [31:0]           j_target;
    logic [31:0]           alu_result;
    logic [NREGS_LOG2-1:0] rs_idx;
    logic [NREGS_LOG2-1:0] rt_idx;
    logic [NREGS_LOG2-1:0] rd_idx;
    logic [NREGS_LOG2-1:0] dest_idx;
    logic [31:0]           wb_data;
    logic [DMEM_AW-1:0]    mem_addr;
    logic                  mem_we;

    assign bus.instr_req  = instr_req_reg;
    assign bus.instr_addr = pc_reg[IMEM_AW+1:2];
    assign halted         = halted_reg;
    assign halt_value     = halt_value_reg;
    assign retired        = retired_reg;

    // Register indices alias modulo the register-file size.
    assign rs_idx = NREGS_LOG2'(ir_reg[25:21]);
    assign rt_idx = NREGS_LOG2'(ir_reg[20:16]);
    assign rd_idx = NREGS_LOG2'(ir_reg[15:11]);

    assign imm       = {{16{ir_reg[15]}}, ir_reg[15:0]};
    assign pc4       = pc_reg + 32'd4;
    assign br_target = pc4 + (imm << 2);
    assign j_target  = {pc4[31:28], ir_reg[25:0], 2'b00};

    always_comb begin
        kind = K_BAD;
        case (ir_reg[31:26])
            6'h00: begin
                case (ir_reg[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: kind = K_RALU;
                    6'h0D:                                           kind = K_BREAK;
                    default:                                         kind = K_BAD;
                endcase
            end
            6'h08:   kind = K_ADDI;
            6'h23:   kind = K_LW;
            6'h2B:   kind = K_SW;
            6'h04:   kind = K_BEQ;
            6'h05:   kind = K_BNE;
            6'h02:   kind = K_J;
            default: kind = K_BAD;
        endcase
    end

    // addi/lw/sw share the a+imm path; shifts take their amount from the shamt field.
    always_comb begin
        alu_result = a_reg + imm;
        if (kind == K_RALU) begin
            case (ir_reg[5:0])
                6'h20:   alu_result = a_reg + b_reg;
                6'h22:   alu_result = a_reg - b_reg;
                6'h24:   alu_result = a_reg & b_reg;
                6'h25:   alu_result = a_reg | b_reg;
                6'h2A:   alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
                6'h00:   alu_result = b_reg << ir_reg[10:6];
                6'h02:   alu_result = b_reg >> ir_reg[10:6];
                default: alu_result = a_reg + b_reg;
            endcase
        end
    end

    assign dest_idx = (kind == K_RALU) ? rd_idx : rt_idx;
    assign wb_data  = (kind == K_LW) ? mem_rdata_reg : alu_out_reg;
    assign mem_addr = alu_out_reg[DMEM_AW+1:2];
    assign mem_we   = (state_reg == S_MEM) && (kind == K_SW);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= S_FETCH;
            pc_reg         <= '0;
            ir_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            alu_out_reg    <= '0;
            instr_req_reg  <= 1'b1;
            halted_reg     <= 1'b0;
            halt_value_reg <= '0;
            retired_reg    <= '0;
            for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        ir_reg        <= bus.instr;
                        instr_req_reg <= 1'b0;
                        state_reg     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_reg <= regs_reg[rs_idx];
                    b_reg <= regs_reg[rt_idx];
                    if (kind == K_BREAK) begin
                        halt_value_reg <= regs_reg[rs_idx];
                        halted_reg     <= 1'b1;
                        retired_reg    <= retired_reg + 32'd1;
                        state_reg      <= S_HALT;
                    end else begin
                        state_reg <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    alu_out_reg <= alu_result;
                    case (kind)
                        K_RALU, K_ADDI: state_reg <= S_WB;
                        K_LW, K_SW:     state_reg <= S_MEM;
                        default: begin
                            // Control transfers and unsupported encodings retire here.
                            if (kind == K_J)
                                pc_reg <= j_target;
                            else if ((kind == K_BEQ && a_reg == b_reg) || (kind == K_BNE && a_reg != b_reg))
                                pc_reg <= br_target;
                            else
                                pc_reg <= pc4;
                            retired_reg   <= retired_reg + 32'd1;
                            instr_req_reg <= 1'b1;
                            state_reg     <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (kind == K_SW) begin
                        pc_reg        <= pc4;
                        retired_reg   <= retired_reg + 32'd1;
                        instr_req_reg <= 1'b1;
                        state_reg     <= S_FETCH;
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_WB: begin
                    if (dest_idx != '0) regs_reg[dest_idx] <= wb_data;
                    pc_reg        <= pc4;
                    retired_reg   <= retired_reg + 32'd1;
                    instr_req_reg <= 1'b1;
                    state_reg     <= S_FETCH;
                end
                S_HALT: state_reg <= S_HALT;
                default: begin
                    instr_req_reg <= 1'b1;
                    state_reg     <= S_FETCH;
                end
            endcase
        end
    end

    // Data RAM keeps its contents across reset; a store commits only on its MEM edge.
    always_ff @(posedge clock) begin
        if (mem_we) dmem[mem_addr] <= b_reg;
        mem_rdata_reg <= dmem[mem_addr];
    end
endmodule
